// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: op codes, FSM states, default memory size.
package lsu_pkg;

    localparam logic [1:0] OP_LOAD    = 2'b00;
    localparam logic [1:0] OP_STORE   = 2'b01;
    localparam logic [1:0] OP_COPY    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int LSU_MEM_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CP_RD,
        ST_CP_WR,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_addr_gen.sv
// Effective address (base + signed offset, wrapping) and range checks; purely combinational.
// Copy ends are evaluated one bit wider so a run crossing 2^ADDR_W cannot alias back in range.
module lsu_addr_gen #(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 16
) (
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_offset,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [3:0]        i_len,
    output logic [ADDR_W-1:0] o_ea,
    output logic              o_ea_oob,
    output logic              o_copy_oob
);

    localparam logic [ADDR_W:0] LP_DEPTH = MEM_DEPTH[ADDR_W:0];

    logic [ADDR_W:0] w_len_x;
    logic [ADDR_W:0] w_src_end;
    logic [ADDR_W:0] w_dst_end;

    assign o_ea      = i_base + i_offset;
    assign w_len_x   = {{(ADDR_W-3){1'b0}}, i_len};
    assign w_src_end = {1'b0, o_ea} + w_len_x - 1'b1;
    assign w_dst_end = {1'b0, i_dst} + w_len_x - 1'b1;

    assign o_ea_oob   = {1'b0, o_ea} >= LP_DEPTH;
    assign o_copy_oob = (w_src_end >= LP_DEPTH) || (w_dst_end >= LP_DEPTH)
                     || ({1'b0, i_dst} >= LP_DEPTH);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: load/store in 2 cycles after accept, copy of N bytes in 2N+1, faults in 1.
// Accepts only in IDLE (req_ready); responses are a single unstalled strobe.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = LSU_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_len,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_ea;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_resp_data;
    logic [3:0]        r_len;
    logic [3:0]        r_idx;
    logic              r_resp_fault;

    logic [ADDR_W-1:0] w_ea;
    logic [ADDR_W-1:0] w_dst;
    logic              w_ea_oob;
    logic              w_copy_oob;
    logic              w_accept;
    logic              w_fault;
    logic              w_last;

    assign w_dst    = ADDR_W'(req_wdata);
    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_last   = ({1'b0, r_idx} + 5'd1) == {1'b0, r_len};

    lsu_addr_gen #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_addr_gen (
        .i_base     (req_base),
        .i_offset   (req_offset),
        .i_dst      (w_dst),
        .i_len      (req_len),
        .o_ea       (w_ea),
        .o_ea_oob   (w_ea_oob),
        .o_copy_oob (w_copy_oob)
    );

    // A zero-length copy is never a fault, even if its base is out of range.
    always_comb begin
        w_fault = 1'b1;
        case (req_op)
            OP_LOAD, OP_STORE: w_fault = w_ea_oob;
            OP_COPY:           w_fault = (req_len != 4'd0) && w_copy_oob;
            default:           w_fault = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_fault || (req_op == OP_COPY && req_len == 4'd0)) begin
                        w_next = ST_RESP;
                    end else if (req_op == OP_COPY) begin
                        w_next = ST_CP_RD;
                    end else begin
                        w_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: w_next = ST_RESP;
            ST_CP_RD:  w_next = ST_CP_WR;
            ST_CP_WR:  w_next = w_last ? ST_RESP : ST_CP_RD;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= 2'b00;
            r_ea         <= '0;
            r_dst        <= '0;
            r_wdata      <= '0;
            r_buf        <= '0;
            r_resp_data  <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_resp_fault <= 1'b0;
        end else if (w_accept) begin
            r_op         <= req_op;
            r_ea         <= w_ea;
            r_dst        <= w_dst;
            r_wdata      <= req_wdata;
            r_buf        <= '0;
            r_resp_data  <= '0;
            r_len        <= req_len;
            r_idx        <= '0;
            r_resp_fault <= w_fault;
        end else begin
            case (r_state)
                ST_ACCESS: if (r_op == OP_LOAD) r_resp_data <= mem_rdata;
                ST_CP_RD:  r_buf <= mem_rdata;
                ST_CP_WR: begin
                    r_idx <= r_idx + 4'd1;
                    if (w_last) r_resp_data <= DATA_W'(r_len);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_fault = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_ACCESS: begin
                mem_addr = r_ea;
                if (r_op == OP_LOAD) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                    mem_wdata = r_wdata;
                end
            end
            ST_CP_RD: begin
                mem_read = 1'b1;
                mem_addr = r_ea + ADDR_W'(r_idx);
            end
            ST_CP_WR: begin
                mem_write = 1'b1;
                mem_addr  = r_dst + ADDR_W'(r_idx);
                mem_wdata = r_buf;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_data  = r_resp_data;
                resp_fault = r_resp_fault;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random requests against a byte-level memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_base = 8'h00;
    logic [7:0] req_offset = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic [3:0] req_len = 4'h0;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_fault;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] ram [16] = '{default: 8'h00};
    logic [7:0] ref_mem [16] = '{default: 8'h00};

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [17:0] exp_q[$];
    logic [7:0]  exp_data;
    logic        exp_fault;
    logic [7:0]  last_data;

    logic [1:0] r_op;
    logic [7:0] r_base, r_off, r_wd;
    logic [3:0] r_len;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_base   (req_base),
        .req_offset (req_offset),
        .req_wdata  (req_wdata),
        .req_len    (req_len),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_fault (resp_fault),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = (mem_read && mem_addr < 8'd16) ? ram[mem_addr[3:0]] : 8'h00;

    always @(posedge clk) begin
        if (mem_write && mem_addr < 8'd16) ram[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: expected strobe trace, response and memory effect, straight from the op rules.
    task automatic model(input logic [1:0] op, input logic [7:0] base, input logic [7:0] off,
                         input logic [7:0] wd, input logic [3:0] len);
        int ea, src_end, dst_end;
        logic [7:0] b;
        exp_q.delete();
        exp_data  = 8'h00;
        exp_fault = 1'b0;
        ea = (int'(base) + int'(off)) % 256;
        case (op)
            OP_LOAD: begin
                if (ea >= 16) exp_fault = 1'b1;
                else begin
                    exp_q.push_back({1'b1, 1'b0, 8'(ea), 8'h00});
                    exp_data = ref_mem[ea];
                end
            end
            OP_STORE: begin
                if (ea >= 16) exp_fault = 1'b1;
                else begin
                    exp_q.push_back({1'b0, 1'b1, 8'(ea), wd});
                    ref_mem[ea] = wd;
                end
            end
            OP_COPY: begin
                if (len != 0) begin
                    src_end = ea + int'(len) - 1;
                    dst_end = int'(wd) + int'(len) - 1;
                    if (src_end >= 16 || dst_end >= 16 || int'(wd) >= 16) exp_fault = 1'b1;
                    else begin
                        for (int i = 0; i < int'(len); i++) begin
                            b = ref_mem[ea + i];
                            exp_q.push_back({1'b1, 1'b0, 8'(ea + i), 8'h00});
                            exp_q.push_back({1'b0, 1'b1, 8'(int'(wd) + i), b});
                            ref_mem[int'(wd) + i] = b;
                        end
                        exp_data = 8'(len);
                    end
                end
            end
            default: exp_fault = 1'b1;
        endcase
    endtask

    // Called at a negedge while IDLE; returns at the negedge after the accepting edge,
    // leaving a junk request asserted that the busy unit must ignore.
    task automatic issue(input logic [1:0] op, input logic [7:0] base, input logic [7:0] off,
                         input logic [7:0] wd, input logic [3:0] len);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_base = base; req_offset = off;
        req_wdata = wd; req_len = len;
        @(negedge clk);
        req_op = OP_STORE; req_base = 8'h00; req_offset = 8'h00; req_wdata = 8'hEE; req_len = 4'h0;
    endtask

    task automatic run_req(input logic [1:0] op, input logic [7:0] base, input logic [7:0] off,
                           input logic [7:0] wd, input logic [3:0] len);
        model(op, base, off, wd, len);
        issue(op, base, off, wd, len);
        foreach (exp_q[i]) begin
            check("strobe", {14'd0, mem_read, mem_write, mem_addr, mem_wdata}, {14'd0, exp_q[i]});
            check("no_resp_busy", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("resp_data", {24'd0, resp_data}, {24'd0, exp_data});
        check("resp_fault", {31'd0, resp_fault}, {31'd0, exp_fault});
        check("resp_strobes", {14'd0, mem_read, mem_write, mem_addr, mem_wdata}, 32'd0);
        check("ready_busy", {31'd0, req_ready}, 32'd0);
        last_data = resp_data;
        @(negedge clk);
        check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #1;
        check("rst_outputs", {resp_valid, resp_data, resp_fault, mem_read, mem_write, mem_addr, mem_wdata}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_req(OP_STORE, 8'h04, 8'h03, 8'h5A, 4'd0);
        run_req(OP_LOAD,  8'h07, 8'h00, 8'h00, 4'd0);
        check("load_5a", {24'd0, last_data}, 32'h5A);
        run_req(OP_LOAD,  8'h02, 8'hFF, 8'h00, 4'd0);
        run_req(OP_LOAD,  8'h0F, 8'h01, 8'h00, 4'd0);
        run_req(OP_LOAD,  8'h0F, 8'h00, 8'h00, 4'd0);
        run_req(OP_STORE, 8'hFF, 8'h01, 8'h77, 4'd0);
        run_req(OP_STORE, 8'h00, 8'h00, 8'h11, 4'd0);
        run_req(OP_STORE, 8'h01, 8'h00, 8'h22, 4'd0);
        run_req(OP_STORE, 8'h02, 8'h00, 8'h33, 4'd0);
        run_req(OP_COPY,  8'h00, 8'h00, 8'h08, 4'd3);
        check("copy_len", {24'd0, last_data}, 32'd3);
        check("ram8", {24'd0, ram[8]}, 32'h11);
        check("ram9", {24'd0, ram[9]}, 32'h22);
        check("ramA", {24'd0, ram[10]}, 32'h33);
        run_req(OP_COPY,    8'h00, 8'h00, 8'h0E, 4'd3);
        run_req(OP_ILLEGAL, 8'h00, 8'h00, 8'h00, 4'd0);
        run_req(OP_COPY,    8'h00, 8'h00, 8'h08, 4'd0);
        run_req(OP_COPY,    8'h0D, 8'h00, 8'h00, 4'd3);
        run_req(OP_COPY,    8'h01, 8'h00, 8'h02, 4'd4);

        // Abort a copy during the second read; the first byte written must survive.
        run_req(OP_STORE, 8'h08, 8'h00, 8'h00, 4'd0);
        run_req(OP_STORE, 8'h09, 8'h00, 8'h00, 4'd0);
        run_req(OP_STORE, 8'h00, 8'h00, 8'h11, 4'd0);
        issue(OP_COPY, 8'h00, 8'h00, 8'h08, 4'd3);
        check("ab_rd0", {14'd0, mem_read, mem_write, mem_addr, mem_wdata}, {14'd0, 2'b10, 8'h00, 8'h00});
        @(negedge clk);
        check("ab_wr8", {14'd0, mem_read, mem_write, mem_addr, mem_wdata}, {14'd0, 2'b01, 8'h08, 8'h11});
        @(negedge clk);
        check("ab_rd1", {14'd0, mem_read, mem_write, mem_addr, mem_wdata}, {14'd0, 2'b10, 8'h01, 8'h00});
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        check("ab_outputs", {resp_valid, resp_data, resp_fault, mem_read, mem_write, mem_addr, mem_wdata}, 32'd0);
        check("ab_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("ab_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        check("ab_ram8", {24'd0, ram[8]}, 32'h11);
        check("ab_ram9", {24'd0, ram[9]}, 32'h00);
        ref_mem[8] = 8'h11;
        ref_mem[9] = 8'h00;

        for (int n = 0; n < 60; n++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_base = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
            r_off  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4))
                                                 : 8'(0 - int'($urandom_range(0, 4)));
            r_wd   = (r_op == OP_COPY) ? 8'($urandom_range(0, 17)) : 8'($urandom);
            r_len  = 4'($urandom_range(0, 6));
            run_req(r_op, r_base, r_off, r_wd, r_len);
        end

        for (int a = 0; a < 16; a++) begin
            check("final_ram", {24'd0, ram[a]}, {24'd0, ref_mem[a]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port of the tiny 8-bit CPU. It accepts load, store and short block-copy requests from the core over a valid/ready handshake and computes the effective address (base + signed offset). It range-checks that address, drives the data memory's read/write strobes, address and write data, and captures the memory's combinational read data. Each request returns one single-cycle response carrying data and a fault flag.

## Interface
Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- MEM_DEPTH, 16, number of implemented memory bytes; valid addresses are 0..MEM_DEPTH-1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; 1 only in IDLE.
- req_op  in  2  operation: 00 load, 01 store, 10 copy, 11 illegal.
- req_base  in  ADDR_W  base address; source base for copy.
- req_offset  in  ADDR_W  signed two's-complement offset; applies to the source for copy.
- req_wdata  in  DATA_W  store data; destination base for copy.
- req_len  in  4  copy length in bytes, 0..15; ignored otherwise.
- resp_valid  out  1  one-cycle response strobe.
- resp_data  out  DATA_W  meaning depends on op:
  - load: loaded byte.
  - copy: bytes copied.
  - store or fault: 0.
- resp_fault  out  1  address out of range or illegal op; qualified by resp_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, combinational from mem_read/mem_addr.

## Operation
- FSM states: IDLE, ACCESS, CP_RD, CP_WR, RESP.
- Effective address: ea = (req_base + req_offset) mod 2^ADDR_W (8-bit wrap). All captured into registers at acceptance.
- IDLE: req_ready=1. On req_valid:
  - Illegal op, or load/store with ea ≥ MEM_DEPTH: go to RESP with fault=1, no memory strobe.
  - Load/store in range: go to ACCESS.
  - Copy with len=0: go to RESP, data 0, fault 0.
  - Copy range check: compute src_end = ea+len-1 and dst_end = req_wdata+len-1 in ADDR_W+1 bits. If either end ≥ MEM_DEPTH, or req_wdata ≥ MEM_DEPTH, go to RESP with fault=1. Otherwise go to CP_RD with index i=0.
- ACCESS: one cycle.
  - Load: mem_read=1, mem_addr=ea; mem_rdata is registered at the closing edge.
  - Store: mem_write=1, mem_addr=ea, mem_wdata=stored data.
  - Then go to RESP.
- CP_RD: mem_read=1, mem_addr=src+i; mem_rdata is latched into a 1-byte buffer. Then go to CP_WR.
- CP_WR: mem_write=1, mem_addr=dst+i, mem_wdata=buffer; i increments.
  - If i+1 == len: go to RESP with data=len.
  - Otherwise: go to CP_RD.
  - Copy proceeds ascending; overlapping ranges are copied byte-by-byte in that order, with no memmove semantics.
- RESP: resp_valid=1 for exactly one cycle with registered data/fault, then go to IDLE. The core has no back-pressure on responses.
- mem_read and mem_write are never 1 simultaneously.
- Outside ACCESS/CP_RD/CP_WR, both strobes are 0 and mem_addr/mem_wdata are 0.
- req_valid outside IDLE is ignored; the request is not consumed because req_ready=0.

## Timing
- Reset (async assert): state IDLE; resp_valid, resp_data, resp_fault, mem_read, mem_write, mem_addr, mem_wdata all 0; req_ready=1; internal registers cleared.
- Reset mid-operation aborts immediately with no response. Memory writes completed before reset are kept.
- Latency counts clock edges after the accepting edge:
  - Load/store: ACCESS in cycle 1, resp_valid in cycle 2.
  - Fault or len=0: resp_valid in cycle 1.
  - Copy of N bytes: CP cycles 1..2N, resp_valid in cycle 2N+1.
- Back-to-back: a new request can be accepted on the cycle after RESP (IDLE), so there is a 3-cycle minimum period for load/store.

## Structure
- Package lsu_pkg holds:
  - op encodings (OP_LOAD, OP_STORE, OP_COPY);
  - the state enum;
  - the default MEM_DEPTH.
- One combinational sub-module, lsu_addr_gen, performs the ea computation and the range check; it is shared by the load/store and copy paths.

## Test plan
- Store: op=01, base 0x04, offset 0x03, wdata 0x5A -> mem_write=1 with addr 0x07 for exactly one cycle; resp_valid 2 cycles after accept; fault 0; resp_data 0.
- Load: op=00 to 0x07 after the previous store -> mem_read cycle at 0x07; resp_data 0x5A; fault 0.
- Negative offset: base 0x02, offset 0xFF, load -> access at 0x01. Then base 0x0F, offset 0x01 (ea 0x10) -> fault=1 after 1 cycle, no strobes, resp_data 0.
- Copy: src 0x00 (contents 11,22,33), dst 0x08, len 3 -> strobe sequence R0,W8,R1,W9,R2,WA; ram[8..A]=11,22,33; resp_data 3 at cycle 7.
- Copy range faults, each with no strobes and fault=1:
  - dst 0x0E, len 3;
  - op=11.
  - Copy len 0 -> resp_data 0, fault 0.
- Reset asserted during CP_RD of the second byte of the previous copy -> all outputs 0 asynchronously, no resp_valid, req_ready=1, ram[8]=0x11 retained.
